display_refresh_sequencer: RTL and testbench

DISPLAY_REFRESH_SEQUENCER -- requirements
Module: display_refresh_sequencer

---
 rtl/clock_display_pkg.sv | 38 +++
 rtl/bcd_to_seg7.sv | 25 ++
 rtl/display_refresh_sequencer.sv | 163 ++++++++++++++++
 tb/tb_display_refresh_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_display_pkg.sv
// Shared types and constants for the clock display refresh path:
// sequencer state encoding, seven-segment codes and the serial frame layout.
package clock_display_pkg;

  localparam int unsigned FRAME_BITS = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DONE
  } state_t;

  // Segment order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] DASH_SEG  = 7'h40;
  localparam logic [6:0] BLANK_SEG = 7'h00;

  // One byte per digit, {dp, g..a}, first-shifted digit in the top byte
  typedef struct packed {
    logic [7:0] hours_tens;
    logic [7:0] hours_ones;
    logic [7:0] minutes_tens;
    logic [7:0] minutes_ones;
  } frame_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to seven-segment decoder; codes 10..15 show a dash.
module bcd_to_seg7 (
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);
  import clock_display_pkg::*;

  always_comb begin
    seg_c = DASH_SEG;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = DASH_SEG;
    endcase
  end

endmodule

// File: rtl/display_refresh_sequencer.sv
// Shifts a 4-digit HH:MM seven-segment frame into an external shift register.
// Optional BLANK_LEADING_ZERO_EN blanks a leading zero on the hours-tens digit.
module display_refresh_sequencer #(
  parameter int unsigned SYS_CLK_HZ   = 5_000_000,
  parameter int unsigned SHIFT_CLK_HZ = 1_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic       i_refresh_stb,
  input  logic [7:0] i_hours_bcd,
  input  logic [7:0] i_minutes_bcd,
  input  logic       i_colon,
  output logic       o_serial_data,
  output logic       o_serial_clk,
  output logic       o_serial_latch,
  output logic       o_busy,
  output logic       o_done
);
  import clock_display_pkg::*;

  localparam int unsigned HALF_RAW = SYS_CLK_HZ / (2 * SHIFT_CLK_HZ);
  localparam int unsigned HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int unsigned DIV_W    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned BIT_W    = $clog2(FRAME_BITS);

  logic [6:0] ht_seg_c;
  logic [6:0] ho_seg_c;
  logic [6:0] mt_seg_c;
  logic [6:0] mo_seg_c;
  logic [6:0] ht_disp_c;

  bcd_to_seg7 u_hours_tens   (.bcd(i_hours_bcd[7:4]),   .seg_c(ht_seg_c));
  bcd_to_seg7 u_hours_ones   (.bcd(i_hours_bcd[3:0]),   .seg_c(ho_seg_c));
  bcd_to_seg7 u_minutes_tens (.bcd(i_minutes_bcd[7:4]), .seg_c(mt_seg_c));
  bcd_to_seg7 u_minutes_ones (.bcd(i_minutes_bcd[3:0]), .seg_c(mo_seg_c));

`ifdef BLANK_LEADING_ZERO_EN
  assign ht_disp_c = (i_hours_bcd[7:4] == 4'd0) ? BLANK_SEG : ht_seg_c;
`else
  assign ht_disp_c = ht_seg_c;
`endif

  frame_t                frame_c;
  logic [FRAME_BITS-1:0] frame_bits_c;

  // The colon lights the decimal point of the hours-ones digit only
  assign frame_c = '{
    hours_tens:   {1'b0,    ht_disp_c},
    hours_ones:   {i_colon, ho_seg_c},
    minutes_tens: {1'b0,    mt_seg_c},
    minutes_ones: {1'b0,    mo_seg_c}
  };
  assign frame_bits_c = frame_c;

  state_t                state;
  logic                  pending;
  logic [FRAME_BITS-1:0] shreg;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DIV_W-1:0]      div_cnt;

  logic start_c;
  logic div_last_c;
  logic bit_last_c;

  assign start_c    = (i_refresh_stb | pending) & i_en;
  assign div_last_c = (div_cnt == DIV_W'(HALF - 1));
  assign bit_last_c = (bit_cnt == BIT_W'(FRAME_BITS - 1));

  // Sequencer: state, counters, pending request and all registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= IDLE;
      pending        <= 1'b0;
      shreg          <= '0;
      bit_cnt        <= '0;
      div_cnt        <= '0;
      o_serial_data  <= 1'b0;
      o_serial_clk   <= 1'b0;
      o_serial_latch <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      // Any strobe not consumed below is remembered; repeats merge
      if (i_refresh_stb) pending <= 1'b1;

      unique case (state)
        IDLE: begin
          if (start_c) begin
            state   <= LOAD;
            o_busy  <= 1'b1;
            pending <= 1'b0;
          end
        end

        LOAD: begin
          shreg         <= frame_bits_c;
          o_serial_data <= frame_bits_c[FRAME_BITS-1];
          bit_cnt       <= '0;
          div_cnt       <= '0;
          state         <= SHIFT_LO;
        end

        SHIFT_LO: begin
          if (div_last_c) begin
            div_cnt      <= '0;
            o_serial_clk <= 1'b1;
            state        <= SHIFT_HI;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        SHIFT_HI: begin
          if (div_last_c) begin
            div_cnt      <= '0;
            o_serial_clk <= 1'b0;
            if (bit_last_c) begin
              o_serial_latch <= 1'b1;
              state          <= LATCH;
            end else begin
              // Rotate so the next bit sits in the MSB; data only moves here
              bit_cnt       <= bit_cnt + BIT_W'(1);
              shreg         <= {shreg[FRAME_BITS-2:0], shreg[FRAME_BITS-1]};
              o_serial_data <= shreg[FRAME_BITS-2];
              state         <= SHIFT_LO;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        LATCH: begin
          if (div_last_c) begin
            div_cnt        <= '0;
            o_serial_latch <= 1'b0;
            o_done         <= 1'b1;
            state          <= DONE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        DONE: begin
          o_done <= 1'b0;
          if (start_c) begin
            state   <= LOAD;
            pending <= 1'b0;
          end else begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_refresh_sequencer.sv
// Bench for display_refresh_sequencer: one instance with HALF=1, one with HALF=3.
module tb_display_refresh_sequencer;

  logic       clk = 1'b0;
  logic [1:0] rst;
  logic [1:0] en;
  logic [1:0] stb;
  logic [1:0] col;
  logic [7:0] hr [2];
  logic [7:0] mn [2];
  logic [1:0] sd;
  logic [1:0] sc;
  logic [1:0] sl;
  logic [1:0] bz;
  logic [1:0] dn;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] seg_tbl [10];
  int         stb_plan [$];
  bit         scramble = 1'b0;

  always #5 clk = ~clk;

  display_refresh_sequencer #(.SYS_CLK_HZ(2), .SHIFT_CLK_HZ(1)) dut_h1 (
    .i_clk(clk), .i_reset(rst[0]), .i_en(en[0]), .i_refresh_stb(stb[0]),
    .i_hours_bcd(hr[0]), .i_minutes_bcd(mn[0]), .i_colon(col[0]),
    .o_serial_data(sd[0]), .o_serial_clk(sc[0]), .o_serial_latch(sl[0]),
    .o_busy(bz[0]), .o_done(dn[0])
  );

  display_refresh_sequencer #(.SYS_CLK_HZ(6), .SHIFT_CLK_HZ(1)) dut_h3 (
    .i_clk(clk), .i_reset(rst[1]), .i_en(en[1]), .i_refresh_stb(stb[1]),
    .i_hours_bcd(hr[1]), .i_minutes_bcd(mn[1]), .i_colon(col[1]),
    .o_serial_data(sd[1]), .o_serial_clk(sc[1]), .o_serial_latch(sl[1]),
    .o_busy(bz[1]), .o_done(dn[1])
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got still running, expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] digit_code(input logic [3:0] d);
    if (d > 4'd9) return 8'h40;
    return seg_tbl[int'(d)];
  endfunction

  function automatic logic [31:0] model_frame(input logic [7:0] h, input logic [7:0] m, input logic c);
    logic [7:0] ht;
    ht = digit_code(h[7:4]);
`ifdef BLANK_LEADING_ZERO_EN
    if (h[7:4] == 4'd0) ht = 8'h00;
`endif
    return {ht, digit_code(h[3:0]) | {c, 7'b0}, digit_code(m[7:4]), digit_code(m[3:0])};
  endfunction

  function automatic int half_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic bit in_plan(input int c);
    foreach (stb_plan[i]) if (stb_plan[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(input int k, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bz[k] !== 1'b0) cnt++;
    end
  endtask

  // Pulses the strobe; returns sampling the first frame cycle (LOAD)
  task automatic start_frame(input int k, input logic [7:0] h, input logic [7:0] m,
                             input logic c, input string name);
    hr[k]  = h;
    mn[k]  = m;
    col[k] = c;
    stb[k] = 1'b1;
    tick();
    stb[k] = 1'b0;
    n_checks++;
    if ({bz[k], sc[k], sl[k], dn[k]} !== 4'b1000)
      $display("FAIL %s_start: got busy/clk/latch/done=%b expected 1000", name, {bz[k], sc[k], sl[k], dn[k]});
    else n_pass++;
  endtask

  // Walks one whole frame from its LOAD cycle through its DONE cycle,
  // comparing every cycle to the ideal waveform and decoding the shifted bits.
  task automatic run_frame(input int k, input logic [31:0] exp_bits, input string name,
                           output logic [31:0] got);
    int         h;
    int         total;
    int         bad_c;
    int         nbits;
    logic [4:0] got_v;
    logic [4:0] exp_v;
    logic       prev_sc;
    logic       e_clk, e_lat, e_done, e_d, chk_d;
    h       = half_of(k);
    total   = 2 + 65 * h;
    bad_c   = -1;
    nbits   = 0;
    got     = '0;
    prev_sc = 1'b0;
    got_v   = '0;
    exp_v   = '0;
    for (int c = 0; c < total; c++) begin
      if (c > 0) tick();
      stb[k] = in_plan(c);
      if (scramble && c == 1) begin
        hr[k]  = 8'($urandom);
        mn[k]  = 8'($urandom);
        col[k] = 1'($urandom);
      end
      e_clk = 1'b0; e_lat = 1'b0; e_done = 1'b0; e_d = 1'b0; chk_d = 1'b0;
      if (c >= 1 && c < 1 + 64 * h) begin
        e_clk = ((c - 1) % (2 * h)) >= h;
        e_d   = exp_bits[31 - (c - 1) / (2 * h)];
        chk_d = 1'b1;
      end else if (c >= 1 + 64 * h && c < 1 + 65 * h) begin
        e_lat = 1'b1;
      end else if (c == total - 1) begin
        e_done = 1'b1;
      end
      if (bad_c < 0 && (bz[k] !== 1'b1 || sc[k] !== e_clk || sl[k] !== e_lat ||
                        dn[k] !== e_done || (chk_d && sd[k] !== e_d))) begin
        bad_c = c;
        got_v = {bz[k], sc[k], sl[k], dn[k], sd[k]};
        exp_v = {1'b1, e_clk, e_lat, e_done, chk_d ? e_d : sd[k]};
      end
      if (sc[k] === 1'b1 && prev_sc === 1'b0) begin
        got = {got[30:0], sd[k]};
        nbits++;
      end
      prev_sc = sc[k];
    end
    n_checks++;
    if (bad_c >= 0)
      $display("FAIL %s_trace: cycle %0d got busy/clk/latch/done/data=%b expected %b", name, bad_c, got_v, exp_v);
    else n_pass++;
    n_checks++;
    if (nbits != 32 || got !== exp_bits)
      $display("FAIL %s_bits: got %h (%0d clocks) expected %h (32 clocks)", name, got, nbits, exp_bits);
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 2'b11; en = 2'b11; stb = 2'b00; col = 2'b00;
    hr[0] = 8'h00; hr[1] = 8'h00; mn[0] = 8'h00; mn[1] = 8'h00;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({sd[k], sc[k], sl[k], bz[k], dn[k]} !== 5'b00000)
        $display("FAIL reset_outputs[%0d]: got %b expected 00000", k, {sd[k], sc[k], sl[k], bz[k], dn[k]});
      else n_pass++;
    end
    rst = 2'b00;
    tick();
  endtask

  task automatic test_fixed_frame();
    logic [31:0] got;
    start_frame(0, 8'h12, 8'h34, 1'b1, "fixed");
    run_frame(0, model_frame(8'h12, 8'h34, 1'b1), "fixed", got);
    n_checks++;
    if (got !== 32'h06DB4F66) $display("FAIL fixed_bytes: got %h expected 06db4f66", got);
    else n_pass++;
    tick();
    n_checks++;
    if (bz[0] !== 1'b0) $display("FAIL fixed_idle_after: got busy=%b expected 0", bz[0]);
    else n_pass++;
  endtask

  task automatic test_digits();
    logic [31:0] got;
    logic [7:0]  exp_ht;
`ifdef BLANK_LEADING_ZERO_EN
    exp_ht = 8'h00;
`else
    exp_ht = 8'h3F;
`endif
    start_frame(0, 8'h09, 8'h5A, 1'b0, "digits");
    run_frame(0, model_frame(8'h09, 8'h5A, 1'b0), "digits", got);
    n_checks++;
    if (got[31:24] !== exp_ht) $display("FAIL digits_hours_tens: got %h expected %h", got[31:24], exp_ht);
    else n_pass++;
    n_checks++;
    if (got[15:8] !== 8'h6D) $display("FAIL digits_minutes_tens: got %h expected 6d", got[15:8]);
    else n_pass++;
    n_checks++;
    if (got[7:0] !== 8'h40) $display("FAIL digits_minutes_ones: got %h expected 40", got[7:0]);
    else n_pass++;
    tick();
  endtask

  task automatic test_half3();
    logic [31:0] got;
    start_frame(1, 8'h12, 8'h34, 1'b0, "half3");
    run_frame(1, model_frame(8'h12, 8'h34, 1'b0), "half3", got);
    tick();
  endtask

  task automatic test_random();
    logic [31:0] got;
    logic [31:0] exp_bits;
    logic [7:0]  h, m;
    logic        c;
    int          k;
    scramble = 1'b1;
    for (int i = 0; i < 12; i++) begin
      k = int'($urandom_range(0, 1));
      h = 8'($urandom);
      m = 8'($urandom);
      c = 1'($urandom);
      exp_bits = model_frame(h, m, c);
      start_frame(k, h, m, c, $sformatf("rand%0d", i));
      run_frame(k, exp_bits, $sformatf("rand%0d", i), got);
      tick();
      n_checks++;
      if (bz[k] !== 1'b0) $display("FAIL rand%0d_idle_after: got busy=%b expected 0", i, bz[k]);
      else n_pass++;
    end
    scramble = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    int          cnt;
    start_frame(0, 8'h23, 8'h59, 1'b1, "b2b");
    stb_plan = '{5, 20, 41};
    run_frame(0, model_frame(8'h23, 8'h59, 1'b1), "b2b_first", got);
    stb_plan = {};
    tick();
    n_checks++;
    if ({bz[0], sc[0], sl[0], dn[0]} !== 4'b1000)
      $display("FAIL b2b_second_start: got busy/clk/latch/done=%b expected 1000", {bz[0], sc[0], sl[0], dn[0]});
    else n_pass++;
    run_frame(0, model_frame(8'h23, 8'h59, 1'b1), "b2b_second", got);
    count_busy(0, 80, cnt);
    n_checks++;
    if (cnt != 0) $display("FAIL b2b_no_third: got %0d busy cycles expected 0", cnt);
    else n_pass++;
  endtask

  task automatic test_coincident();
    logic [31:0] got;
    int          cnt;
    start_frame(1, 8'h07, 8'h45, 1'b1, "coinc");
    stb_plan = '{2 + 65 * half_of(1) - 1};
    run_frame(1, model_frame(8'h07, 8'h45, 1'b1), "coinc_first", got);
    stb_plan = {};
    tick();
    stb[1] = 1'b0;
    n_checks++;
    if ({bz[1], sc[1], sl[1], dn[1]} !== 4'b1000)
      $display("FAIL coinc_second_start: got busy/clk/latch/done=%b expected 1000", {bz[1], sc[1], sl[1], dn[1]});
    else n_pass++;
    run_frame(1, model_frame(8'h07, 8'h45, 1'b1), "coinc_second", got);
    count_busy(1, 20, cnt);
    n_checks++;
    if (cnt != 0) $display("FAIL coinc_no_third: got %0d busy cycles expected 0", cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cnt;
    start_frame(0, 8'h18, 8'h88, 1'b1, "midrst");
    // Bit index 10 begins 1 + 10*2*HALF cycles after LOAD; a strobe pends first
    for (int c = 1; c <= 21; c++) begin
      tick();
      stb[0] = (c == 5);
    end
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    n_checks++;
    if ({sd[0], sc[0], sl[0], bz[0], dn[0]} !== 5'b00000)
      $display("FAIL midrst_outputs: got data/clk/latch/busy/done=%b expected 00000",
               {sd[0], sc[0], sl[0], bz[0], dn[0]});
    else n_pass++;
    count_busy(0, 150, cnt);
    n_checks++;
    if (cnt != 0) $display("FAIL midrst_no_frame: got %0d busy cycles expected 0", cnt);
    else n_pass++;
  endtask

  task automatic test_enable();
    logic [31:0] got;
    int          cnt;
    hr[1] = 8'h10; mn[1] = 8'h02; col[1] = 1'b1;
    en[1] = 1'b0;
    stb[1] = 1'b1;
    tick();
    stb[1] = 1'b0;
    count_busy(1, 30, cnt);
    n_checks++;
    if (cnt != 0) $display("FAIL en_low_idle: got %0d busy cycles expected 0", cnt);
    else n_pass++;
    en[1] = 1'b1;
    tick();
    n_checks++;
    if ({bz[1], sc[1], sl[1], dn[1]} !== 4'b1000)
      $display("FAIL en_raise_start: got busy/clk/latch/done=%b expected 1000", {bz[1], sc[1], sl[1], dn[1]});
    else n_pass++;
    run_frame(1, model_frame(8'h10, 8'h02, 1'b1), "en_pending", got);
    tick();
    // Enable dropped mid-frame: the frame completes, a new strobe waits
    start_frame(1, 8'h21, 8'h37, 1'b0, "en_drop");
    en[1] = 1'b0;
    stb_plan = '{10};
    run_frame(1, model_frame(8'h21, 8'h37, 1'b0), "en_drop", got);
    stb_plan = {};
    count_busy(1, 15, cnt);
    n_checks++;
    if (cnt != 0) $display("FAIL en_drop_held: got %0d busy cycles expected 0", cnt);
    else n_pass++;
    en[1] = 1'b1;
    tick();
    n_checks++;
    if ({bz[1], sc[1], sl[1], dn[1]} !== 4'b1000)
      $display("FAIL en_drop_resume: got busy/clk/latch/done=%b expected 1000", {bz[1], sc[1], sl[1], dn[1]});
    else n_pass++;
    run_frame(1, model_frame(8'h21, 8'h37, 1'b0), "en_drop_resume", got);
    tick();
  endtask

  initial begin
    seg_tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    test_reset();
    test_fixed_frame();
    test_digits();
    test_half3();
    test_random();
    test_back_to_back();
    test_coincident();
    test_reset_mid();
    test_enable();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
